// File: rtl/tdf_pattern_sequencer_if.sv
// Bundle of the pattern-sequencer control, table-load, DUT and result signals.
// The master side is the run controller/test environment, the slave side is the sequencer.
interface tdf_pattern_sequencer_if #(
  parameter int N_IN  = 4,
  parameter int IDX_W = 2
);
  logic             start;
  logic [IDX_W:0]   run_len;
  logic             load_we;
  logic [IDX_W-1:0] load_addr;
  logic [N_IN-1:0]  load_v1;
  logic [N_IN-1:0]  load_v2;
  logic             load_exp;
  logic [N_IN-1:0]  dut_in;
  logic             dut_out;
  logic             busy;
  logic             done;
  logic             capture_valid;
  logic [IDX_W-1:0] capture_idx;
  logic             capture_val;
  logic             mismatch;
  logic [IDX_W:0]   fail_count;
  logic             pass;

  modport master (
    output start, run_len, load_we, load_addr, load_v1, load_v2, load_exp, dut_out,
    input  dut_in, busy, done, capture_valid, capture_idx, capture_val, mismatch,
           fail_count, pass
  );

  modport slave (
    input  start, run_len, load_we, load_addr, load_v1, load_v2, load_exp, dut_out,
    output dut_in, busy, done, capture_valid, capture_idx, capture_val, mismatch,
           fail_count, pass
  );
endinterface

// File: rtl/tdf_pattern_sequencer.sv
// Two-vector (transition-delay) pattern applicator: holds V1, launches V2, samples
// the DUT response after a fixed delay and scores it against the stored expectation.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | dut_in parked at 0, table writable, waiting for start
// INIT    | V1[idx] applied, settle timer running
// LAUNCH  | V2[idx] applied, capture timer running
// CAPTURE | V2[idx] still applied, dut_out sampled at the end of cycle
// DONE    | single cycle, done pulse, pass computed on the way out
module tdf_pattern_sequencer #(
  parameter int N_IN        = 4,
  parameter int N_PAT       = 4,
  parameter int SETTLE_CYC  = 4,
  parameter int CAPTURE_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  tdf_pattern_sequencer_if.slave bus
);
  localparam int IDX_W   = (N_PAT > 1) ? $clog2(N_PAT) : 1;
  localparam int TMR_MAX = (SETTLE_CYC > CAPTURE_CYC) ? SETTLE_CYC : CAPTURE_CYC;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    LAUNCH  = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t state, state_nx;

  logic [N_IN-1:0]  v1_mem  [N_PAT];
  logic [N_IN-1:0]  v2_mem  [N_PAT];
  logic             exp_mem [N_PAT];

  logic [TMR_W-1:0] timer, timer_nx;
  logic [IDX_W-1:0] idx, idx_nx;
  logic [IDX_W-1:0] last_idx, last_nx;
  logic [N_IN-1:0]  dut_in_q, dut_in_nx;
  logic             busy_q, busy_nx;
  logic             done_q, done_nx;
  logic             cv_q, cv_nx;
  logic [IDX_W-1:0] cidx_q, cidx_nx;
  logic             cval_q, cval_nx;
  logic             mm_q, mm_nx;
  logic [IDX_W:0]   fail_q, fail_nx;
  logic             pass_q, pass_nx;

  logic             table_we;
  logic [N_IN-1:0]  v1_first;
  logic [IDX_W-1:0] eff_last;
  logic             miss;

  // Table writes are only honoured while the sequencer is parked.
  assign table_we = (state == IDLE) && bus.load_we;

  // A write to entry 0 in the start cycle must already be visible to the first V1.
  assign v1_first = (table_we && (bus.load_addr == '0)) ? bus.load_v1 : v1_mem[0];

  // Zero or an over-long request both mean "run the whole table".
  assign eff_last = ((bus.run_len == '0) || (bus.run_len > (IDX_W+1)'(N_PAT)))
                    ? IDX_W'(N_PAT - 1)
                    : IDX_W'(bus.run_len - 1'b1);

  // Pattern table storage; deliberately not reset so patterns survive a run abort.
  always_ff @(posedge clk) begin
    if (table_we) begin
      v1_mem[bus.load_addr]  <= bus.load_v1;
      v2_mem[bus.load_addr]  <= bus.load_v2;
      exp_mem[bus.load_addr] <= bus.load_exp;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state, timer, index and next-output decode.
  always_comb begin
    state_nx  = state;
    timer_nx  = timer;
    idx_nx    = idx;
    last_nx   = last_idx;
    dut_in_nx = '0;
    cv_nx     = 1'b0;
    cidx_nx   = cidx_q;
    cval_nx   = cval_q;
    mm_nx     = mm_q;
    fail_nx   = fail_q;
    pass_nx   = pass_q;
    miss      = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nx  = INIT;
          idx_nx    = '0;
          last_nx   = eff_last;
          fail_nx   = '0;
          pass_nx   = 1'b0;
          timer_nx  = TMR_W'(SETTLE_CYC - 1);
          dut_in_nx = v1_first;
        end
      end
      INIT: begin
        dut_in_nx = v1_mem[idx];
        if (timer == '0) begin
          state_nx  = LAUNCH;
          timer_nx  = TMR_W'(CAPTURE_CYC - 1);
          dut_in_nx = v2_mem[idx];
        end else begin
          timer_nx = timer - 1'b1;
        end
      end
      LAUNCH: begin
        dut_in_nx = v2_mem[idx];
        if (timer == '0) state_nx = CAPTURE;
        else             timer_nx = timer - 1'b1;
      end
      CAPTURE: begin
        miss    = (bus.dut_out != exp_mem[idx]);
        cv_nx   = 1'b1;
        cidx_nx = idx;
        cval_nx = bus.dut_out;
        mm_nx   = miss;
        fail_nx = fail_q + (IDX_W+1)'(miss);
        if (idx == last_idx) begin
          state_nx = DONE;
        end else begin
          state_nx  = INIT;
          idx_nx    = idx + 1'b1;
          timer_nx  = TMR_W'(SETTLE_CYC - 1);
          dut_in_nx = v1_mem[idx + 1'b1];
        end
      end
      DONE: begin
        state_nx = IDLE;
        pass_nx  = (fail_q == '0);
      end
      default: state_nx = IDLE;
    endcase

    busy_nx = (state_nx != IDLE);
    done_nx = (state_nx == DONE);
  end

  // Registered datapath and outputs; everything but the table returns to rest on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer    <= '0;
      idx      <= '0;
      last_idx <= '0;
      dut_in_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cv_q     <= 1'b0;
      cidx_q   <= '0;
      cval_q   <= 1'b0;
      mm_q     <= 1'b0;
      fail_q   <= '0;
      pass_q   <= 1'b0;
    end else begin
      timer    <= timer_nx;
      idx      <= idx_nx;
      last_idx <= last_nx;
      dut_in_q <= dut_in_nx;
      busy_q   <= busy_nx;
      done_q   <= done_nx;
      cv_q     <= cv_nx;
      cidx_q   <= cidx_nx;
      cval_q   <= cval_nx;
      mm_q     <= mm_nx;
      fail_q   <= fail_nx;
      pass_q   <= pass_nx;
    end
  end

  assign bus.dut_in        = dut_in_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.capture_valid = cv_q;
  assign bus.capture_idx   = cidx_q;
  assign bus.capture_val   = cval_q;
  assign bus.mismatch      = mm_q;
  assign bus.fail_count    = fail_q;
  assign bus.pass          = pass_q;

endmodule
